// File: rtl/twofish_subkey_gen.sv
// rtl/twofish_subkey_gen.sv - iterative Twofish (k=2) round-subkey generator with a shared h function

// Twofish h function for a two-word key list: chained q0/q1 byte permutations
// keyed by l1 then l0, followed by the MDS matrix over GF(2^8) mod 0x169.
// Bytes and words are little-endian: byte j of x is x[8j+7:8j].
module h_function (
  input  logic [31:0] x,
  input  logic [31:0] l0,
  input  logic [31:0] l1,
  output logic [31:0] z
);

  // 4-bit substitution tables; entry 0 sits in the most significant nibble
  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] sel);
    logic [5:0] pos;
    pos = 6'd60 - {sel, 2'b00};
    return tbl[pos +: 4];
  endfunction

  function automatic logic [3:0] ror4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // Two Feistel-like nibble rounds; {a[0],3'b0} is 8*a mod 16
  function automatic logic [7:0] q_perm(input logic [7:0] v,
                                        input logic [63:0] t0, input logic [63:0] t1,
                                        input logic [63:0] t2, input logic [63:0] t3);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = v[7:4];
    b0 = v[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = nib(t0, a1);
    b2 = nib(t1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = nib(t2, a3);
    b4 = nib(t3, b3);
    return {b4, a4};
  endfunction

  function automatic logic [7:0] q0(input logic [7:0] v);
    return q_perm(v, Q0_T0, Q0_T1, Q0_T2, Q0_T3);
  endfunction

  function automatic logic [7:0] q1(input logic [7:0] v);
    return q_perm(v, Q1_T0, Q1_T1, Q1_T2, Q1_T3);
  endfunction

  // Shift-and-add multiply; 0x69 is the reduction polynomial 0x169 without x^8
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ 8'h69) : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  logic [7:0] y0, y1, y2, y3;

  // Keyed permutation chain per byte lane, then MDS mix into z
  always_comb begin
    y0 = q1(q0(q0(x[7:0])   ^ l1[7:0])   ^ l0[7:0]);
    y1 = q0(q0(q1(x[15:8])  ^ l1[15:8])  ^ l0[15:8]);
    y2 = q1(q1(q0(x[23:16]) ^ l1[23:16]) ^ l0[23:16]);
    y3 = q0(q1(q1(x[31:24]) ^ l1[31:24]) ^ l0[31:24]);
    z[7:0]   = y0 ^ gf_mul(8'hEF, y1) ^ gf_mul(8'h5B, y2) ^ gf_mul(8'h5B, y3);
    z[15:8]  = gf_mul(8'h5B, y0) ^ gf_mul(8'hEF, y1) ^ gf_mul(8'hEF, y2) ^ y3;
    z[23:16] = gf_mul(8'hEF, y0) ^ gf_mul(8'h5B, y1) ^ y2 ^ gf_mul(8'hEF, y3);
    z[31:24] = gf_mul(8'hEF, y0) ^ y1 ^ gf_mul(8'hEF, y2) ^ gf_mul(8'h5B, y3);
  end

endmodule

// Generates NUM_SUBKEYS subkeys as NUM_SUBKEYS/2 pairs, three cycles per pair:
// CALC_A computes and stores A, CALC_B computes B and both outputs, OUT waits
// for the consumer. A single h_function is shared between the A and B steps.
module twofish_subkey_gen #(
  parameter int          NUM_SUBKEYS = 40,
  parameter logic [31:0] RHO         = 32'h01010101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] me0,
  input  logic [31:0] me1,
  input  logic [31:0] mo0,
  input  logic [31:0] mo1,
  output logic        busy,
  output logic        k_valid,
  input  logic        k_ready,
  output logic [31:0] k_even,
  output logic [31:0] k_odd,
  output logic [5:0]  k_idx,
  output logic        done
);

  localparam logic [5:0] LAST_PAIR = 6'(NUM_SUBKEYS / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC_A,
    S_CALC_B,
    S_OUT
  } state_t;

  state_t      state;
  logic [31:0] me0_q, me1_q, mo0_q, mo1_q;
  logic [31:0] a_q;
  logic [5:0]  pair_q;

  logic        sel_odd;
  logic [31:0] x_mult;
  logic [31:0] h_x, h_l0, h_l1, h_z;
  logic [31:0] b_word, sum_ab, sum_a2b, k_odd_next;

  // Operand mux for the shared h function: even/Me words in CALC_A, odd/Mo in CALC_B
  always_comb begin
    sel_odd    = (state == S_CALC_B);
    x_mult     = {25'd0, pair_q, sel_odd};
    h_x        = x_mult * RHO;
    h_l0       = sel_odd ? mo0_q : me0_q;
    h_l1       = sel_odd ? mo1_q : me1_q;
    b_word     = {h_z[23:0], h_z[31:24]};
    sum_ab     = a_q + b_word;
    sum_a2b    = a_q + {b_word[30:0], 1'b0};
    k_odd_next = {sum_a2b[22:0], sum_a2b[31:23]};
  end

  h_function u_h (
    .x  (h_x),
    .l0 (h_l0),
    .l1 (h_l1),
    .z  (h_z)
  );

  // Sequencer: key latching, A register, pair counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      me0_q   <= 32'd0;
      me1_q   <= 32'd0;
      mo0_q   <= 32'd0;
      mo1_q   <= 32'd0;
      a_q     <= 32'd0;
      pair_q  <= 6'd0;
      busy    <= 1'b0;
      k_valid <= 1'b0;
      k_even  <= 32'd0;
      k_odd   <= 32'd0;
      k_idx   <= 6'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            me0_q  <= me0;
            me1_q  <= me1;
            mo0_q  <= mo0;
            mo1_q  <= mo1;
            pair_q <= 6'd0;
            busy   <= 1'b1;
            state  <= S_CALC_A;
          end
        end
        S_CALC_A: begin
          a_q   <= h_z;
          state <= S_CALC_B;
        end
        S_CALC_B: begin
          k_even  <= sum_ab;
          k_odd   <= k_odd_next;
          k_idx   <= pair_q;
          k_valid <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (k_ready) begin
            k_valid <= 1'b0;
            if (pair_q == LAST_PAIR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              pair_q <= pair_q + 6'd1;
              state  <= S_CALC_A;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
